// File: rtl/mask_window_sequencer.sv
// Frame sequencer for an M_SIZE x M_SIZE window: shift enables, end-of-frame
// padding flush, and registered centre strobe with coordinates and in-image masks.
//
// Ports:
//   clk, reset (async, active-high)
//   in_valid, in_sof -> in_ready    : raw pixel stream
//   shift_en, pad                   : combinational window shift / padding beat
//   center_valid, center_x/y        : registered centre strobe and position
//   row_mask, col_mask              : bit k set iff window row/col k is inside the image
//   frame_done                      : pulse with the last centre of a frame
//   err_sync                        : pulse one cycle after a protocol error
//
// Build option: define SOF_RESYNC_EN so that in_sof during RUN aborts the
// current frame and restarts on that pixel; otherwise such an in_sof is ignored.
module mask_window_sequencer #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int M_SIZE     = 11,
  parameter int X_W        = $clog2(IMG_WIDTH),
  parameter int Y_W        = $clog2(IMG_HEIGHT)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic              in_sof,
  output logic              in_ready,
  output logic              shift_en,
  output logic              pad,
  output logic              center_valid,
  output logic [X_W-1:0]    center_x,
  output logic [Y_W-1:0]    center_y,
  output logic [M_SIZE-1:0] row_mask,
  output logic [M_SIZE-1:0] col_mask,
  output logic              frame_done,
  output logic              err_sync
);

  localparam int HALF  = M_SIZE / 2;
  localparam int NPIX  = IMG_WIDTH * IMG_HEIGHT;
  localparam int LEAD  = HALF * IMG_WIDTH + HALF;
  localparam int TOTAL = NPIX + LEAD;
  localparam int CW    = $clog2(TOTAL) + 1;

  localparam logic [CW-1:0]  S_LEAD    = CW'(LEAD);
  localparam logic [CW-1:0]  S_LASTPIX = CW'(NPIX - 1);
  localparam logic [CW-1:0]  S_LASTPAD = CW'(TOTAL - 1);
  localparam logic [X_W-1:0] X_LAST    = X_W'(IMG_WIDTH - 1);
  localparam logic [Y_W-1:0] Y_LAST    = Y_W'(IMG_HEIGHT - 1);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  state_t         state;
  logic [CW-1:0]  s;
  logic [X_W-1:0] cx;
  logic [Y_W-1:0] cy;

  logic           accept;
  logic           sof_run;
  logic           resync;
  logic           emit;
  logic           last_c;
  logic [CW-1:0]  s_pre;
  logic [X_W-1:0] cx_cur;
  logic [Y_W-1:0] cy_cur;
  logic [M_SIZE-1:0] row_m;
  logic [M_SIZE-1:0] col_m;

  // Bit k set iff coordinate c-HALF+k falls inside [0, lim).
  function automatic logic [M_SIZE-1:0] in_mask(input int c, input int lim);
    logic [M_SIZE-1:0] m;
    m = '0;
    for (int k = 0; k < M_SIZE; k++) begin
      m[k] = (c - HALF + k >= 0) && (c - HALF + k < lim);
    end
    return m;
  endfunction

  always_comb begin
    in_ready = (state != FLUSH);
    pad      = (state == FLUSH);
    accept   = in_valid & ((state == RUN) | ((state == IDLE) & in_sof));
    sof_run  = (state == RUN) & in_valid & in_sof;
`ifdef SOF_RESYNC_EN
    resync   = sof_run;
`else
    resync   = 1'b0;
`endif
    shift_en = accept | pad;
    // A resync pixel is shift 0 of a fresh frame with centres from (0,0).
    s_pre    = resync ? '0 : s;
    cx_cur   = resync ? '0 : cx;
    cy_cur   = resync ? '0 : cy;
    emit     = shift_en & (s_pre >= S_LEAD);
    last_c   = (cx_cur == X_LAST) & (cy_cur == Y_LAST);
    row_m    = in_mask(int'(cy_cur), IMG_HEIGHT);
    col_m    = in_mask(int'(cx_cur), IMG_WIDTH);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      s            <= '0;
      cx           <= '0;
      cy           <= '0;
      center_valid <= 1'b0;
      frame_done   <= 1'b0;
      err_sync     <= 1'b0;
      center_x     <= '0;
      center_y     <= '0;
      row_mask     <= '0;
      col_mask     <= '0;
    end else begin
      err_sync     <= ((state == IDLE) & in_valid & ~in_sof) | sof_run;
      center_valid <= emit;
      frame_done   <= emit & last_c;

      if (emit) begin
        center_x <= cx_cur;
        center_y <= cy_cur;
        row_mask <= row_m;
        col_mask <= col_m;
        if (cx_cur == X_LAST) begin
          cx <= '0;
          cy <= (cy_cur == Y_LAST) ? '0 : cy_cur + 1'b1;
        end else begin
          cx <= cx_cur + 1'b1;
          cy <= cy_cur;
        end
      end else if (resync) begin
        cx <= '0;
        cy <= '0;
      end

      unique case (state)
        IDLE: begin
          if (accept) begin
            s     <= CW'(1);
            state <= RUN;
          end
        end
        RUN: begin
          if (accept) begin
            s <= s_pre + 1'b1;
            if (s_pre == S_LASTPIX) state <= FLUSH;
          end
        end
        FLUSH: begin
          if (s == S_LASTPAD) begin
            s     <= '0;
            state <= IDLE;
          end else begin
            s <= s + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mask_window_sequencer.md
Name: mask_window_sequencer

Overview:
- Frame-level controller for the M_SIZE×M_SIZE window datapath that feeds edge/colour mask merging.
- Accepts the raw pixel stream and drives line-buffer shift enables.
- Inserts padding beats at end of frame to flush the window.
- Emits a registered center-pixel strobe with coordinates and per-row/per-column in-image masks. The datapath uses the masks to set each window pixel's validity bit.

Parameters:
- IMG_WIDTH, 640, pixels per line (must be ≥ M_SIZE).
- IMG_HEIGHT, 480, lines per frame (must be ≥ M_SIZE).
- M_SIZE, 11, window dimension (odd); HALF = M_SIZE/2.
- X_W, $clog2(IMG_WIDTH), x coordinate width.
- Y_W, $clog2(IMG_HEIGHT), y coordinate width.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  input pixel present
- in_sof  in  1  qualifies first pixel of a frame (meaningful only with in_valid)
- in_ready  out  1  sequencer accepts a pixel this cycle
- shift_en  out  1  combinational; datapath shifts the window this cycle
- pad  out  1  combinational; shifted pixel is padding (datapath writes invalid/zero)
- center_valid  out  1  registered; window centered on (center_x, center_y) is complete
- center_x  out  X_W  center column
- center_y  out  Y_W  center row
- row_mask  out  M_SIZE  bit k=1 iff window row (center_y−HALF+k) lies in [0, IMG_HEIGHT)
- col_mask  out  M_SIZE  bit k=1 iff window column (center_x−HALF+k) lies in [0, IMG_WIDTH)
- frame_done  out  1  registered pulse, coincident with the last center of the frame
- err_sync  out  1  registered pulse on protocol error

Behaviour:
- Reset (async, immediate): state=IDLE; all counters 0; center_valid, frame_done, err_sync, center_x, center_y, row_mask, col_mask = 0. in_ready=1 because state is IDLE.
- States:
  - IDLE: in_ready=1.
    - in_valid & in_sof → accept; shift count S=1; go to RUN.
    - in_valid & !in_sof → drop the pixel (no shift_en); err_sync pulses next cycle.
  - RUN: in_ready=1; each in_valid is accepted and S increments.
    - Accepting pixel number IMG_WIDTH*IMG_HEIGHT → go to FLUSH.
  - FLUSH: in_ready=0; shift_en=1 and pad=1 every cycle; S increments.
    - After HALF*IMG_WIDTH+HALF pad beats → go to IDLE.
    - in_valid during FLUSH is ignored and is not an error.
- shift_en = (in_valid & in_ready & accepted) | (state==FLUSH). pad=1 only in FLUSH.
- Center generation:
  - A shift with pre-increment S ≥ HALF*IMG_WIDTH+HALF produces a center.
  - center_valid=1 on the following cycle, with the current (cx, cy).
  - cx then advances, wrapping at IMG_WIDTH−1 with cy+1.
  - Outputs hold their values when center_valid=0.
- Masks are computed from (cx, cy) using signed compare and registered with center_valid.
- frame_done=1 on the same cycle as the center (IMG_WIDTH−1, IMG_HEIGHT−1).
- Center counters reset to 0 on frame_done.
- Shift beats per frame = IMG_WIDTH*IMG_HEIGHT + HALF*IMG_WIDTH + HALF.
- No back-to-back frames during FLUSH. A new frame may start the cycle after the return to IDLE.
- in_sof during RUN: behaviour is per the Optional Feature. Either way err_sync pulses one cycle later.
- Counters are sized for IMG_WIDTH*(IMG_HEIGHT+HALF)+HALF with no overflow. Width rule: $clog2 of that value + 1.

Optional Feature:
- Macro: SOF_RESYNC_EN.
- Defined: in_sof in RUN aborts the current frame.
  - All counters clear.
  - That pixel is accepted as pixel 0 of a new frame (S=1, stay in RUN).
  - No frame_done for the aborted frame.
  - Centers of the aborted frame that are not yet emitted are discarded.
- Undefined: in_sof in RUN is ignored and the pixel is accepted as a normal pixel. Frame sequencing is unchanged.

Test Plan (IMG_WIDTH=8, IMG_HEIGHT=4, M_SIZE=3, HALF=1):
- Reset mid-FLUSH → next cycle: in_ready=1, center_valid=0, all outputs 0. Then a clean frame completes normally.
- One frame, in_valid held high, in_sof on first beat:
  - 32 accepted + 9 pad beats (41 shift_en).
  - First center_valid one cycle after the 10th shift: (0,0), row_mask=3'b110, col_mask=3'b110.
  - 32 centers total.
  - Last center (7,3): row_mask=3'b011, col_mask=3'b011, frame_done=1.
- Interior check: center (3,1) → row_mask=3'b111, col_mask=3'b111. Center (7,0) → col_mask=3'b011, row_mask=3'b110.
- Gapped input (in_valid 50% random) → identical center sequence and masks. FLUSH still lasts exactly 9 consecutive cycles with in_ready=0.
- in_valid without in_sof in IDLE → no shift_en, err_sync=1 one cycle later, state stays IDLE.
- in_sof on pixel 12 of a frame:
  - With SOF_RESYNC_EN: err_sync pulses; centers restart at (0,0) after 10 further shifts; exactly one frame_done.
  - Without SOF_RESYNC_EN: err_sync pulses; FLUSH starts after the 32nd accepted pixel as normal.
